uart_mmio_bridge: RTL and testbench
===================================

# uart_mmio_bridge

Memory-mapped register bridge between the CPU data-memory port and N UART cores. It gives each channel its own configuration registers, a TX FIFO and an RX FIFO, and replaces hard-wired RAM cells with a decoded register window. It also replaces the ad-hoc negedge hang logic with a combinational `stall` that holds the CPU only when a TX FIFO is full. It sits beside `data_mem`: the CPU drives `re`/`we`/`addr`/`wdata` to both, and `hit` selects `rdata` over RAM data.

## Interface
- `N_CH`, 2: number of UART channels (1..8).
- `BASE_ADDR`, 32'h100: word address of channel 0 register 0.
- `TX_DEPTH`, 8: TX FIFO entries per channel (power of 2, ≥2).
- `RX_DEPTH`, 8: RX FIFO entries per channel (power of 2, ≥2).

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `re` in 1: CPU read enable.
- `we` in 1: CPU write enable.
- `addr` in 32: word address (ALU result).
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data; 0 when `!hit` or `!re`.
- `hit` out 1: `addr` falls in [BASE_ADDR, BASE_ADDR+8·N_CH).
- `stall` out 1: combinational; CPU must hold its instruction/PC while high.
- `ubrr` out 12·N_CH: per-channel baud divisor.
- `ucsz` out 4·N_CH: per-channel character size.
- `ucr` out 2·N_CH: per-channel control.
- `tx_data` out 8·N_CH: byte presented to the core.
- `tx_load` out N_CH: one-cycle load strobe per channel.
- `tx_busy` in N_CH: core transmitter busy (the core's USR[0]).
- `rx_byte` in 8·N_CH: received byte.
- `rx_strobe` in N_CH: one-cycle pulse, `rx_byte` valid.

## Operation
- Decode: `off = addr − BASE_ADDR`; channel `c = off[..3]`, register `r = off[2:0]`. Out-of-range addresses give `hit=0`, `rdata=0`, and writes are ignored.
- Register map, per channel:
  - 0 UBRR: rw, [11:0].
  - 1 UCSZ: rw, [3:0].
  - 2 UCR: rw, [1:0].
  - 3 UDRT: write pushes `wdata[7:0]` to the TX FIFO; reads 0.
  - 4 USR: read-only except bit 3.
    - bit0: TX FIFO full.
    - bit1: RX FIFO non-empty.
    - bit2: TX FIFO empty and `!tx_busy`.
    - bit3: RX overrun, sticky; writing 1 to bit3 clears it.
  - 5 UDRR: read returns the RX head byte (0 if empty); the posedge with `re && !stall` pops it.
  - 6 TXCNT: TX occupancy, read-only.
  - 7 RXCNT: RX occupancy, read-only.
- Register writes take effect on the posedge where `we && hit && !stall`. Unused upper bits read 0.
- `stall = we && hit && r==3 && tx_full[c]`. Reads never stall; reading an empty UDRR returns 0 with no pop.
- TX drain FSM, per channel, states IDLE → LOAD → GUARD → IDLE:
  - IDLE: if FIFO non-empty and `!tx_busy`, register `tx_data` = head, pop, and set `tx_load` = 1; next state LOAD.
  - LOAD: `tx_load` = 0, next state GUARD. GUARD covers the cycle the core needs to raise busy.
  - GUARD: return to IDLE.
  - Minimum spacing between loads is 3 cycles.
- RX: on `rx_strobe[c]`, push `rx_byte` if the FIFO is not full. If full, drop the byte and set overrun.
- Simultaneous events:
  - CPU push and drain pop on the same TX FIFO in one cycle: both occur, count unchanged.
  - RX push and CPU pop in one cycle: both occur, and the full check uses the pre-pop count, so a byte arriving while full is dropped even if a pop happens that cycle.
  - Overrun set and a W1C clear in the same cycle: set wins.
- Pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Counts are `log2(DEPTH)+1` bits; full when count == DEPTH.

## Timing
- Reset (async, immediate):
  - all config registers 0; FIFOs empty; counts 0; overrun 0;
  - FSMs in IDLE; `tx_load` = 0; `tx_data` = 0.
  - `rdata`, `hit` and `stall` follow the inputs combinationally (0 with idle bus).
- Reset asserted mid-transfer: FIFO contents are discarded and any `tx_load` pulse is cut; the core is not otherwise notified.
- Write-to-`tx_load` latency: with an empty FIFO and idle core, `tx_load` goes high 1 cycle after the UDRT write edge.
- A stalled write completes on the first posedge after `tx_full` drops. Because `stall` is computed from the current count, this is the edge after the one where the drain pops.
- `rx_strobe` to USR bit1: visible the cycle after the strobe edge.

## Test plan
- Reset, then read every register of channel 0 and of channel N_CH−1 → all 0, `hit=1`; read `BASE_ADDR+8·N_CH` → `hit=0`, `rdata=0`.
- Write UBRR=0xFFF, UCSZ=0x1F, UCR=3 on ch1 → `ubrr[23:12]`=0xFFF, `ucsz[7:4]`=0xF, `ucr[3:2]`=3; ch0 config unchanged.
- Hold `tx_busy[0]=1`, write 9 bytes 0x41..0x49 to ch0 UDRT (depth 8):
  - 9th write asserts `stall`; TXCNT=8.
  - Release busy: `tx_load` pulses with 0x41 first, the stalled write completes, and all 9 bytes emerge in order at ≥3-cycle spacing.
- Pulse `rx_strobe[0]` 9 times with 0x10..0x18 → RXCNT=8, USR=0b1010 (overrun, RX non-empty); 8 UDRR reads return 0x10..0x17; a 9th read returns 0 with no pop; writing USR=0x8 clears overrun.
- Same-cycle `rx_strobe` and UDRR read with RXCNT=3 → returned byte is the old head, RXCNT stays 3.
- Assert `rst` while `tx_load` is high with 4 bytes queued → `tx_load` drops immediately; after release TXCNT=0, USR=0b0100.

Source files
------------

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: decoded register window between the CPU data-memory port
// and N_CH UART cores. Each channel has config registers, a TX FIFO drained
// into the core by a small load FSM, and an RX FIFO filled by the core.
module uart_mmio_bridge #(
    parameter int          N_CH      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  hit,
    output logic                  stall,
    output logic [12*N_CH-1:0]    ubrr,
    output logic [4*N_CH-1:0]     ucsz,
    output logic [2*N_CH-1:0]     ucr,
    output logic [8*N_CH-1:0]     tx_data,
    output logic [N_CH-1:0]       tx_load,
    input  logic [N_CH-1:0]       tx_busy,
    input  logic [8*N_CH-1:0]     rx_byte,
    input  logic [N_CH-1:0]       rx_strobe
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
    localparam int TC = TA + 1;
    localparam int RC = RA + 1;
    localparam logic [31:0]   WIN_SIZE = 32'(8 * N_CH);
    localparam logic [TA-1:0] TX_PTR_ONE = TA'(1);
    localparam logic [RA-1:0] RX_PTR_ONE = RA'(1);
    localparam logic [TC-1:0] TX_CNT_ONE = TC'(1);
    localparam logic [RC-1:0] RX_CNT_ONE = RC'(1);
    localparam logic [TC-1:0] TX_FULL = TC'(TX_DEPTH);
    localparam logic [RC-1:0] RX_FULL = RC'(RX_DEPTH);
    localparam logic [TC-1:0] TX_EMPTY = TC'(0);
    localparam logic [RC-1:0] RX_EMPTY = RC'(0);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_GUARD = 2'd2
    } tx_state_e;

    // Address decode
    logic [31:0]   off_s;
    logic [2:0]    reg_s;
    logic [CW-1:0] ch_s;
    logic          hit_s;
    logic          stall_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [31:0]   rdata_s;
    logic [19:0]   wdata_unused_s;

    // Per-channel state
    logic [11:0]   ubrr_q [N_CH];
    logic [11:0]   ubrr_d [N_CH];
    logic [3:0]    ucsz_q [N_CH];
    logic [3:0]    ucsz_d [N_CH];
    logic [1:0]    ucr_q [N_CH];
    logic [1:0]    ucr_d [N_CH];
    logic [7:0]    tx_mem_q [N_CH][TX_DEPTH];
    logic [7:0]    tx_mem_d [N_CH][TX_DEPTH];
    logic [TA-1:0] tx_rd_q [N_CH];
    logic [TA-1:0] tx_rd_d [N_CH];
    logic [TA-1:0] tx_wr_q [N_CH];
    logic [TA-1:0] tx_wr_d [N_CH];
    logic [TC-1:0] tx_cnt_q [N_CH];
    logic [TC-1:0] tx_cnt_d [N_CH];
    logic [7:0]    rx_mem_q [N_CH][RX_DEPTH];
    logic [7:0]    rx_mem_d [N_CH][RX_DEPTH];
    logic [RA-1:0] rx_rd_q [N_CH];
    logic [RA-1:0] rx_rd_d [N_CH];
    logic [RA-1:0] rx_wr_q [N_CH];
    logic [RA-1:0] rx_wr_d [N_CH];
    logic [RC-1:0] rx_cnt_q [N_CH];
    logic [RC-1:0] rx_cnt_d [N_CH];
    logic [N_CH-1:0] ovr_q;
    logic [N_CH-1:0] ovr_d;
    tx_state_e     tx_state_q [N_CH];
    tx_state_e     tx_state_d [N_CH];
    logic [7:0]    tx_data_q [N_CH];
    logic [7:0]    tx_data_d [N_CH];
    logic [N_CH-1:0] tx_load_q;
    logic [N_CH-1:0] tx_load_d;

    // Per-channel event strobes
    logic [N_CH-1:0] sel_s;
    logic [N_CH-1:0] tx_push_s;
    logic [N_CH-1:0] tx_pop_s;
    logic [N_CH-1:0] rx_push_s;
    logic [N_CH-1:0] rx_pop_s;
    logic [N_CH-1:0] ovr_set_s;
    logic [N_CH-1:0] ovr_clr_s;

    // Out-of-window addresses wrap to large offsets, so one compare covers both ends
    assign off_s          = addr - BASE_ADDR;
    assign hit_s          = (off_s < WIN_SIZE);
    assign reg_s          = off_s[2:0];
    assign ch_s           = off_s[3 +: CW];
    assign wr_en_s        = we && hit_s && !stall_s;
    assign rd_en_s        = re && hit_s && !stall_s;
    assign wdata_unused_s = wdata[31:12];
    assign rdata          = rdata_s;
    assign hit            = hit_s;
    assign stall          = stall_s;

    // Combinational read mux and TX-full stall for the addressed channel
    always_comb begin
        rdata_s = 32'd0;
        stall_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit_s && (ch_s == CW'(i))) begin
                stall_s = we && (reg_s == 3'd3) && (tx_cnt_q[i] == TX_FULL);
                if (re) begin
                    case (reg_s)
                        3'd0:    rdata_s = {20'd0, ubrr_q[i]};
                        3'd1:    rdata_s = {28'd0, ucsz_q[i]};
                        3'd2:    rdata_s = {30'd0, ucr_q[i]};
                        3'd4:    rdata_s = {28'd0, ovr_q[i],
                                            (tx_cnt_q[i] == TX_EMPTY) && !tx_busy[i],
                                            (rx_cnt_q[i] != RX_EMPTY),
                                            (tx_cnt_q[i] == TX_FULL)};
                        3'd5:    rdata_s = (rx_cnt_q[i] != RX_EMPTY) ?
                                           {24'd0, rx_mem_q[i][rx_rd_q[i]]} : 32'd0;
                        3'd6:    rdata_s = 32'(tx_cnt_q[i]);
                        3'd7:    rdata_s = 32'(rx_cnt_q[i]);
                        default: rdata_s = 32'd0;
                    endcase
                end else begin
                    rdata_s = 32'd0;
                end
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    // FIFO push/pop and overrun events per channel
    always_comb begin
        sel_s     = {N_CH{1'b0}};
        tx_push_s = {N_CH{1'b0}};
        tx_pop_s  = {N_CH{1'b0}};
        rx_push_s = {N_CH{1'b0}};
        rx_pop_s  = {N_CH{1'b0}};
        ovr_set_s = {N_CH{1'b0}};
        ovr_clr_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            sel_s[i]     = hit_s && (ch_s == CW'(i));
            tx_push_s[i] = wr_en_s && sel_s[i] && (reg_s == 3'd3);
            tx_pop_s[i]  = (tx_state_q[i] == TX_IDLE) && (tx_cnt_q[i] != TX_EMPTY) && !tx_busy[i];
            // Full check uses the pre-pop count: a byte arriving while full is lost
            rx_push_s[i] = rx_strobe[i] && (rx_cnt_q[i] != RX_FULL);
            ovr_set_s[i] = rx_strobe[i] && (rx_cnt_q[i] == RX_FULL);
            rx_pop_s[i]  = rd_en_s && sel_s[i] && (reg_s == 3'd5) && (rx_cnt_q[i] != RX_EMPTY);
            ovr_clr_s[i] = wr_en_s && sel_s[i] && (reg_s == 3'd4) && wdata[3];
        end
    end

    // Next-state logic: config writes, FIFOs, overrun flag and TX drain FSM
    always_comb begin
        ubrr_d     = ubrr_q;
        ucsz_d     = ucsz_q;
        ucr_d      = ucr_q;
        tx_mem_d   = tx_mem_q;
        tx_rd_d    = tx_rd_q;
        tx_wr_d    = tx_wr_q;
        tx_cnt_d   = tx_cnt_q;
        rx_mem_d   = rx_mem_q;
        rx_rd_d    = rx_rd_q;
        rx_wr_d    = rx_wr_q;
        rx_cnt_d   = rx_cnt_q;
        ovr_d      = ovr_q;
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_load_d  = tx_load_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_en_s && sel_s[i]) begin
                case (reg_s)
                    3'd0:    ubrr_d[i] = wdata[11:0];
                    3'd1:    ucsz_d[i] = wdata[3:0];
                    3'd2:    ucr_d[i]  = wdata[1:0];
                    default: ubrr_d[i] = ubrr_q[i];
                endcase
            end else begin
                ubrr_d[i] = ubrr_q[i];
            end

            if (tx_push_s[i]) begin
                tx_mem_d[i][tx_wr_q[i]] = wdata[7:0];
                tx_wr_d[i]              = tx_wr_q[i] + TX_PTR_ONE;
            end else begin
                tx_wr_d[i] = tx_wr_q[i];
            end

            case (tx_state_q[i])
                TX_IDLE: begin
                    if (tx_pop_s[i]) begin
                        tx_data_d[i]  = tx_mem_q[i][tx_rd_q[i]];
                        tx_rd_d[i]    = tx_rd_q[i] + TX_PTR_ONE;
                        tx_load_d[i]  = 1'b1;
                        tx_state_d[i] = TX_LOAD;
                    end else begin
                        tx_load_d[i]  = 1'b0;
                        tx_state_d[i] = TX_IDLE;
                    end
                end
                TX_LOAD: begin
                    tx_load_d[i]  = 1'b0;
                    tx_state_d[i] = TX_GUARD;
                end
                TX_GUARD: begin
                    tx_load_d[i]  = 1'b0;
                    tx_state_d[i] = TX_IDLE;
                end
                default: begin
                    tx_load_d[i]  = 1'b0;
                    tx_state_d[i] = TX_IDLE;
                end
            endcase

            case ({tx_push_s[i], tx_pop_s[i]})
                2'b10:   tx_cnt_d[i] = tx_cnt_q[i] + TX_CNT_ONE;
                2'b01:   tx_cnt_d[i] = tx_cnt_q[i] - TX_CNT_ONE;
                default: tx_cnt_d[i] = tx_cnt_q[i];
            endcase

            if (rx_push_s[i]) begin
                rx_mem_d[i][rx_wr_q[i]] = rx_byte[8*i +: 8];
                rx_wr_d[i]              = rx_wr_q[i] + RX_PTR_ONE;
            end else begin
                rx_wr_d[i] = rx_wr_q[i];
            end

            if (rx_pop_s[i]) begin
                rx_rd_d[i] = rx_rd_q[i] + RX_PTR_ONE;
            end else begin
                rx_rd_d[i] = rx_rd_q[i];
            end

            case ({rx_push_s[i], rx_pop_s[i]})
                2'b10:   rx_cnt_d[i] = rx_cnt_q[i] + RX_CNT_ONE;
                2'b01:   rx_cnt_d[i] = rx_cnt_q[i] - RX_CNT_ONE;
                default: rx_cnt_d[i] = rx_cnt_q[i];
            endcase

            // A new overrun beats a same-cycle clear
            if (ovr_set_s[i]) begin
                ovr_d[i] = 1'b1;
            end else if (ovr_clr_s[i]) begin
                ovr_d[i] = 1'b0;
            end else begin
                ovr_d[i] = ovr_q[i];
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                ubrr_q[i]     <= 12'd0;
                ucsz_q[i]     <= 4'd0;
                ucr_q[i]      <= 2'd0;
                tx_rd_q[i]    <= {TA{1'b0}};
                tx_wr_q[i]    <= {TA{1'b0}};
                tx_cnt_q[i]   <= {TC{1'b0}};
                rx_rd_q[i]    <= {RA{1'b0}};
                rx_wr_q[i]    <= {RA{1'b0}};
                rx_cnt_q[i]   <= {RC{1'b0}};
                tx_state_q[i] <= TX_IDLE;
                tx_data_q[i]  <= 8'd0;
                for (int j = 0; j < TX_DEPTH; j++) begin
                    tx_mem_q[i][j] <= 8'd0;
                end
                for (int j = 0; j < RX_DEPTH; j++) begin
                    rx_mem_q[i][j] <= 8'd0;
                end
            end
            ovr_q     <= {N_CH{1'b0}};
            tx_load_q <= {N_CH{1'b0}};
        end else begin
            ubrr_q     <= ubrr_d;
            ucsz_q     <= ucsz_d;
            ucr_q      <= ucr_d;
            tx_mem_q   <= tx_mem_d;
            tx_rd_q    <= tx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_mem_q   <= rx_mem_d;
            rx_rd_q    <= rx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_cnt_q   <= rx_cnt_d;
            ovr_q      <= ovr_d;
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_load_q  <= tx_load_d;
        end
    end

    // Flatten per-channel registers onto the packed output buses
    always_comb begin
        ubrr    = {(12 * N_CH){1'b0}};
        ucsz    = {(4 * N_CH){1'b0}};
        ucr     = {(2 * N_CH){1'b0}};
        tx_data = {(8 * N_CH){1'b0}};
        tx_load = tx_load_q;
        for (int i = 0; i < N_CH; i++) begin
            ubrr[12*i +: 12]  = ubrr_q[i];
            ucsz[4*i +: 4]    = ucsz_q[i];
            ucr[2*i +: 2]     = ucr_q[i];
            tx_data[8*i +: 8] = tx_data_q[i];
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed self-checking bench for uart_mmio_bridge (N_CH=2, depths 8).
module tb_uart_mmio_bridge;

    logic        clk;
    logic        rst;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        stall;
    logic [23:0] ubrr;
    logic [7:0]  ucsz;
    logic [3:0]  ucr;
    logic [15:0] tx_data;
    logic [1:0]  tx_load;
    logic [1:0]  tx_busy;
    logic [15:0] rx_byte;
    logic [1:0]  rx_strobe;

    int n_tests = 0;
    int n_fail  = 0;

    uart_mmio_bridge #(
        .N_CH(2), .BASE_ADDR(32'h0000_0100), .TX_DEPTH(8), .RX_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .hit(hit), .stall(stall), .ubrr(ubrr), .ucsz(ucsz),
        .ucr(ucr), .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .rx_byte(rx_byte), .rx_strobe(rx_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr = a;
        re   = 1'b1;
        #1;
        d = rdata;
        h = hit;
        tick();
        re = 1'b0;
    endtask

    logic [31:0] d;
    logic        h;
    logic        pending;
    logic        commit;
    int          commit_cyc;
    logic        seen;
    logic [7:0]  got[$];
    int          cyc_at[$];

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        tx_busy = 2'b11; rx_byte = 16'd0; rx_strobe = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_load", 32'(tx_load), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_hit_idle", 32'(hit), 32'h0);
        chk("rst_rdata_idle", rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Reset values of every register of ch0 and ch1 (busy held so USR bit2 = 0)
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 8; r++) begin
                rd(32'h100 + 32'(8 * c + r), d, h);
                chk($sformatf("reset_reg_c%0d_r%0d", c, r), d, 32'h0);
                chk($sformatf("reset_hit_c%0d_r%0d", c, r), 32'(h), 32'h1);
            end
        end
        rd(32'h110, d, h);
        chk("oor_high_hit", 32'(h), 32'h0);
        chk("oor_high_rdata", d, 32'h0);
        rd(32'h0FF, d, h);
        chk("oor_low_hit", 32'(h), 32'h0);

        // Config writes on ch1, upper bits masked
        wr(32'h108, 32'h0000_0FFF);
        wr(32'h109, 32'h0000_001F);
        wr(32'h10A, 32'h0000_0003);
        wr(32'h110, 32'h0000_0ABC);
        chk("ubrr_ch1", 32'(ubrr[23:12]), 32'hFFF);
        chk("ucsz_ch1", 32'(ucsz[7:4]), 32'hF);
        chk("ucr_ch1", 32'(ucr[3:2]), 32'h3);
        chk("ubrr_ch0", 32'(ubrr[11:0]), 32'h0);
        chk("ucsz_ch0", 32'(ucsz[3:0]), 32'h0);
        chk("ucr_ch0", 32'(ucr[1:0]), 32'h0);
        rd(32'h109, d, h);
        chk("ucsz_ch1_read", d, 32'hF);

        // Fill ch0 TX FIFO while the core is busy
        for (int k = 0; k < 8; k++) begin
            wr(32'h103, 32'h41 + 32'(k));
        end
        rd(32'h106, d, h);
        chk("txcnt_full", d, 32'h8);
        rd(32'h104, d, h);
        chk("usr_txfull", d, 32'h1);
        rd(32'h103, d, h);
        chk("udrt_reads_zero", d, 32'h0);

        // 9th write stalls; release busy and watch the drain
        addr = 32'h103; wdata = 32'h49; we = 1'b1;
        #1;
        chk("stall_on_full", 32'(stall), 32'h1);
        tx_busy[0] = 1'b0;
        pending = 1'b1;
        commit_cyc = -1;
        for (int c = 0; c < 60; c++) begin
            commit = pending && !stall;
            tick();
            if (commit) begin
                we = 1'b0;
                pending = 1'b0;
                commit_cyc = c;
            end
            if (tx_load[0]) begin
                got.push_back(tx_data[7:0]);
                cyc_at.push_back(c);
            end
        end
        chk("stalled_write_done", 32'(pending), 32'h0);
        chk("stalled_write_edge", 32'(commit_cyc), 32'h1);
        chk("tx_load_count", 32'(got.size()), 32'h9);
        for (int k = 0; k < 9; k++) begin
            if (k < got.size()) begin
                chk($sformatf("tx_byte_%0d", k), 32'(got[k]), 32'h41 + 32'(k));
                if (k > 0) begin
                    chk($sformatf("tx_spacing_%0d", k), 32'(cyc_at[k] - cyc_at[k-1]), 32'h3);
                end
            end
        end
        rd(32'h106, d, h);
        chk("txcnt_drained", d, 32'h0);
        rd(32'h104, d, h);
        chk("usr_tx_idle", d, 32'h4);

        // Write-to-load latency: one cycle after the write edge
        wr(32'h103, 32'h5A);
        chk("lat_load_low", 32'(tx_load[0]), 32'h0);
        tick();
        chk("lat_load_high", 32'(tx_load[0]), 32'h1);
        chk("lat_data", 32'(tx_data[7:0]), 32'h5A);
        tick();
        chk("lat_load_pulse", 32'(tx_load[0]), 32'h0);
        repeat (3) tick();

        // RX fill with overrun
        tx_busy[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rx_byte[7:0] = 8'h10 + 8'(k);
            rx_strobe[0] = 1'b1;
            tick();
        end
        rx_strobe[0] = 1'b0;
        rd(32'h107, d, h);
        chk("rxcnt_full", d, 32'h8);
        rd(32'h104, d, h);
        chk("usr_overrun", d, 32'hA);
        for (int k = 0; k < 8; k++) begin
            rd(32'h105, d, h);
            chk($sformatf("udrr_%0d", k), d, 32'h10 + 32'(k));
        end
        rd(32'h105, d, h);
        chk("udrr_empty", d, 32'h0);
        rd(32'h107, d, h);
        chk("rxcnt_empty", d, 32'h0);
        rd(32'h104, d, h);
        chk("usr_ovr_sticky", d, 32'h8);
        wr(32'h104, 32'h8);
        rd(32'h104, d, h);
        chk("usr_ovr_cleared", d, 32'h0);

        // Same-cycle RX push and UDRR pop with 3 queued
        for (int k = 0; k < 3; k++) begin
            rx_byte[7:0] = 8'h21 + 8'(k);
            rx_strobe[0] = 1'b1;
            tick();
        end
        rx_strobe[0] = 1'b0;
        addr = 32'h105; re = 1'b1;
        rx_byte[7:0] = 8'h24; rx_strobe[0] = 1'b1;
        #1;
        chk("same_cycle_head", rdata, 32'h21);
        tick();
        re = 1'b0; rx_strobe[0] = 1'b0;
        rd(32'h107, d, h);
        chk("same_cycle_rxcnt", d, 32'h3);
        rd(32'h105, d, h);
        chk("same_cycle_next", d, 32'h22);

        // Reset while tx_load is high with 4 bytes still queued
        for (int k = 0; k < 5; k++) begin
            wr(32'h103, 32'h61 + 32'(k));
        end
        tx_busy[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (tx_load[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midrst_load_seen", 32'(seen), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_load_cut", 32'(tx_load[0]), 32'h0);
        chk("midrst_data_clr", 32'(tx_data[7:0]), 32'h0);
        #2;
        rst = 1'b0;
        tick();
        rd(32'h106, d, h);
        chk("midrst_txcnt", d, 32'h0);
        rd(32'h104, d, h);
        chk("midrst_usr", d, 32'h4);
        chk("midrst_ubrr_ch1", 32'(ubrr[23:12]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
